wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_pkg.sv | 27 ++
 rtl/load_extend.sv | 36 +++
 rtl/wb_stage.sv | 174 +++++++++++++++++
 tb/tb_wb_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage.
// No logic; constants and types only.
// No flow control.
package wb_pkg;

    // Writeback data source selected by the MEM stage.
    typedef enum logic [1:0] {
        WB_SEL_RES  = 2'b00,
        WB_SEL_HILO = 2'b01,
        WB_SEL_LINK = 2'b10,
        WB_SEL_CP0  = 2'b11
    } wb_sel_e;

    // Load kind, used to extract and extend the raw load word.
    typedef enum logic [2:0] {
        LD_NONE = 3'b000,
        LD_LB   = 3'b001,
        LD_LBU  = 3'b010,
        LD_LH   = 3'b011,
        LD_LHU  = 3'b100,
        LD_LW   = 3'b101
    } ld_type_e;

    // Return-address offset for link instructions (skips the delay slot).
    localparam int LINK_OFFSET = 8;

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/halfword of a load word and sign/zero extends it.
// Purely combinational, zero latency.
// No flow control; output follows inputs.
module load_extend
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] result,
    input  logic [2:0]        ld_type,
    input  logic [1:0]        addr_lo,
    output logic [DATA_W-1:0] data
);

    // Zero-pad above the word so byte offsets stay in range even for 16-bit datapaths.
    logic [DATA_W+31:0] padded;
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;

    assign padded   = {32'b0, result};
    assign byte_sel = padded[{addr_lo, 3'b000} +: 8];
    assign half_sel = padded[{addr_lo[1], 4'b0000} +: 16];

    // Extension by load kind; LW and non-loads pass the word through.
    always_comb begin
        data = result;
        case (ld_type)
            LD_LB:   data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            LD_LBU:  data = {{(DATA_W-8){1'b0}}, byte_sel};
            LD_LH:   data = {{(DATA_W-16){half_sel[15]}}, half_sel};
            LD_LHU:  data = {{(DATA_W-16){1'b0}}, half_sel};
            default: data = result;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: holds one instruction, selects its result, writes RF and HI/LO.
// Latency: an accepted instruction commits from the WB register one cycle after acceptance.
// Backpressure: ws_stall holds the current instruction and drops ws_allowin.
module wb_stage
    import wb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int RF_ADDR_W = 5,
    parameter int HILO_EN   = 1
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 ms_valid,
    output logic                 ws_allowin,
    input  logic                 ws_flush,
    input  logic                 ws_stall,

    input  logic [DATA_W-1:0]    ms_pc,
    input  logic [1:0]           ms_sel,
    input  logic                 ms_regwrite,
    input  logic [RF_ADDR_W-1:0] ms_dest,
    input  logic [DATA_W-1:0]    ms_result,
    input  logic [2:0]           ms_ld_type,
    input  logic [1:0]           ms_addr_lo,
    input  logic                 ms_hi_we,
    input  logic                 ms_lo_we,
    input  logic                 ms_hi_read,
    input  logic                 ms_lo_read,
    input  logic [DATA_W-1:0]    ms_hi_wdata,
    input  logic [DATA_W-1:0]    ms_lo_wdata,
    input  logic [DATA_W-1:0]    ms_cp0_rdata,

    output logic                 rf_we,
    output logic [RF_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]    rf_wdata,

    output logic                 fwd_valid,
    output logic [RF_ADDR_W-1:0] fwd_dest,
    output logic [DATA_W-1:0]    fwd_data,

    output logic [DATA_W-1:0]    debug_wb_pc,
    output logic [DATA_W/8-1:0]  debug_wb_rf_wen,
    output logic [RF_ADDR_W-1:0] debug_wb_rf_wnum,
    output logic [DATA_W-1:0]    debug_wb_rf_wdata
);

    logic                 ws_valid;
    logic [DATA_W-1:0]    ws_pc;
    logic [1:0]           ws_sel;
    logic                 ws_regwrite;
    logic [RF_ADDR_W-1:0] ws_dest;
    logic [DATA_W-1:0]    ws_result;
    logic [2:0]           ws_ld_type;
    logic [1:0]           ws_addr_lo;
    logic                 ws_hi_we;
    logic                 ws_lo_we;
    logic                 ws_hi_read;
    logic                 ws_lo_read;
    logic [DATA_W-1:0]    ws_hi_wdata;
    logic [DATA_W-1:0]    ws_lo_wdata;
    logic [DATA_W-1:0]    ws_cp0_rdata;

    logic                 commit;
    logic                 accept;
    logic                 writes_rf;
    logic [DATA_W-1:0]    ld_data;
    logic [DATA_W-1:0]    hi_q;
    logic [DATA_W-1:0]    lo_q;
    logic [DATA_W-1:0]    hilo_data;
    logic [DATA_W-1:0]    wb_data;

    assign ws_allowin = !ws_valid || !ws_stall;
    assign commit     = ws_valid && !ws_stall;
    assign accept     = ms_valid && ws_allowin && !ws_flush;
    assign writes_rf  = ws_regwrite && (ws_dest != '0);

    // WB pipeline register: load on accept, empty when the slot frees with nothing accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid     <= 1'b0;
            ws_pc        <= '0;
            ws_sel       <= '0;
            ws_regwrite  <= 1'b0;
            ws_dest      <= '0;
            ws_result    <= '0;
            ws_ld_type   <= '0;
            ws_addr_lo   <= '0;
            ws_hi_we     <= 1'b0;
            ws_lo_we     <= 1'b0;
            ws_hi_read   <= 1'b0;
            ws_lo_read   <= 1'b0;
            ws_hi_wdata  <= '0;
            ws_lo_wdata  <= '0;
            ws_cp0_rdata <= '0;
        end else if (ws_allowin) begin
            ws_valid <= accept;
            if (accept) begin
                ws_pc        <= ms_pc;
                ws_sel       <= ms_sel;
                ws_regwrite  <= ms_regwrite;
                ws_dest      <= ms_dest;
                ws_result    <= ms_result;
                ws_ld_type   <= ms_ld_type;
                ws_addr_lo   <= ms_addr_lo;
                ws_hi_we     <= ms_hi_we;
                ws_lo_we     <= ms_lo_we;
                ws_hi_read   <= ms_hi_read;
                ws_lo_read   <= ms_lo_read;
                ws_hi_wdata  <= ms_hi_wdata;
                ws_lo_wdata  <= ms_lo_wdata;
                ws_cp0_rdata <= ms_cp0_rdata;
            end
        end
    end

    // HI/LO exist only when enabled; otherwise they read as zero.
    generate
        if (HILO_EN != 0) begin : g_hilo
            // Update at the commit edge so the committing instruction still reads the old value.
            always_ff @(posedge clk) begin
                if (reset) begin
                    hi_q <= '0;
                    lo_q <= '0;
                end else if (commit) begin
                    if (ws_hi_we) hi_q <= ws_hi_wdata;
                    if (ws_lo_we) lo_q <= ws_lo_wdata;
                end
            end
        end else begin : g_no_hilo
            assign hi_q = '0;
            assign lo_q = '0;
        end
    endgenerate

    load_extend #(
        .DATA_W (DATA_W)
    ) u_load_extend (
        .result  (ws_result),
        .ld_type (ws_ld_type),
        .addr_lo (ws_addr_lo),
        .data    (ld_data)
    );

    // HI wins when both reads are flagged.
    assign hilo_data = ws_hi_read ? hi_q : lo_q;

    // Writeback source mux shared by RF write, bypass and debug trace.
    always_comb begin
        wb_data = ld_data;
        case (ws_sel)
            WB_SEL_RES:  wb_data = ld_data;
            WB_SEL_HILO: wb_data = hilo_data;
            WB_SEL_LINK: wb_data = ws_pc + DATA_W'(LINK_OFFSET);
            WB_SEL_CP0:  wb_data = ws_cp0_rdata;
            default:     wb_data = ld_data;
        endcase
    end

    assign rf_we    = commit && writes_rf;
    assign rf_waddr = ws_dest;
    assign rf_wdata = wb_data;

    // Bypass stays valid while stalled: the value is already final.
    assign fwd_valid = ws_valid && writes_rf;
    assign fwd_dest  = ws_dest;
    assign fwd_data  = wb_data;

    assign debug_wb_pc       = ws_pc;
    assign debug_wb_rf_wen   = {(DATA_W/8){rf_we}};
    assign debug_wb_rf_wnum  = ws_dest;
    assign debug_wb_rf_wdata = wb_data;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with hand-computed expectations.
// Inputs driven 1 time unit after the rising edge, outputs checked there too.
// Commits are counted per destination on each falling edge.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ms_valid;
    logic        ws_allowin;
    logic        ws_flush;
    logic        ws_stall;
    logic [31:0] ms_pc;
    logic [1:0]  ms_sel;
    logic        ms_regwrite;
    logic [4:0]  ms_dest;
    logic [31:0] ms_result;
    logic [2:0]  ms_ld_type;
    logic [1:0]  ms_addr_lo;
    logic        ms_hi_we, ms_lo_we, ms_hi_read, ms_lo_read;
    logic [31:0] ms_hi_wdata, ms_lo_wdata, ms_cp0_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fwd_valid;
    logic [4:0]  fwd_dest;
    logic [31:0] fwd_data;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int n_chk  = 0;
    int n_pass = 0;
    int commit_cnt [32];

    always #5 clk = ~clk;

    wb_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ms_valid          (ms_valid),
        .ws_allowin        (ws_allowin),
        .ws_flush          (ws_flush),
        .ws_stall          (ws_stall),
        .ms_pc             (ms_pc),
        .ms_sel            (ms_sel),
        .ms_regwrite       (ms_regwrite),
        .ms_dest           (ms_dest),
        .ms_result         (ms_result),
        .ms_ld_type        (ms_ld_type),
        .ms_addr_lo        (ms_addr_lo),
        .ms_hi_we          (ms_hi_we),
        .ms_lo_we          (ms_lo_we),
        .ms_hi_read        (ms_hi_read),
        .ms_lo_read        (ms_lo_read),
        .ms_hi_wdata       (ms_hi_wdata),
        .ms_lo_wdata       (ms_lo_wdata),
        .ms_cp0_rdata      (ms_cp0_rdata),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .fwd_valid         (fwd_valid),
        .fwd_dest          (fwd_dest),
        .fwd_data          (fwd_data),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    // Count RF commits per destination, once per cycle.
    always @(negedge clk) begin
        if (rf_we) commit_cnt[rf_waddr] = commit_cnt[rf_waddr] + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] sel, input logic rw, input logic [4:0] dest,
                         input logic [31:0] res, input logic [2:0] ld, input logic [1:0] alo);
        ms_valid     = 1'b1;
        ms_pc        = 32'h0000_1000;
        ms_sel       = sel;
        ms_regwrite  = rw;
        ms_dest      = dest;
        ms_result    = res;
        ms_ld_type   = ld;
        ms_addr_lo   = alo;
        ms_hi_we     = 1'b0;
        ms_lo_we     = 1'b0;
        ms_hi_read   = 1'b0;
        ms_lo_read   = 1'b0;
        ms_hi_wdata  = '0;
        ms_lo_wdata  = '0;
        ms_cp0_rdata = '0;
    endtask

    initial begin
        reset    = 1'b1;
        ws_flush = 1'b0;
        ws_stall = 1'b0;
        offer(2'b00, 1'b0, 5'd0, 32'h0, 3'b000, 2'b00);
        ms_valid = 1'b1;
        step();
        step();
        reset    = 1'b0;
        ms_valid = 1'b0;

        // Reset state
        chk("rst_allowin", ws_allowin, 1);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_fwd_valid", fwd_valid, 0);
        chk("rst_dbg_wen", debug_wb_rf_wen, 0);
        chk("rst_dbg_pc", debug_wb_pc, 0);

        // ADDU-style write
        offer(2'b00, 1'b1, 5'd3, 32'h1234_5678, 3'b000, 2'b00);
        ms_pc = 32'hBFC0_0000;
        step();
        chk("addu_we", rf_we, 1);
        chk("addu_waddr", rf_waddr, 3);
        chk("addu_wdata", rf_wdata, 32'h1234_5678);
        chk("addu_fwd", {fwd_valid, fwd_dest, fwd_data}, {1'b1, 5'd3, 32'h1234_5678});
        chk("addu_dbg_wen", debug_wb_rf_wen, 4'hF);
        chk("addu_dbg_pc", debug_wb_pc, 32'hBFC0_0000);
        chk("addu_dbg_wnum", debug_wb_rf_wnum, 3);

        // Loads
        offer(2'b00, 1'b1, 5'd5, 32'h0080_FF11, 3'b001, 2'd2);
        step();
        chk("lb_a2", rf_wdata, 32'hFFFF_FF80);
        offer(2'b00, 1'b1, 5'd5, 32'h0080_FF11, 3'b100, 2'd2);
        step();
        chk("lhu_a2", rf_wdata, 32'h0000_0080);
        offer(2'b00, 1'b1, 5'd5, 32'h0080_FF11, 3'b011, 2'd0);
        step();
        chk("lh_a0", rf_wdata, 32'hFFFF_FF11);
        offer(2'b00, 1'b1, 5'd5, 32'h0080_FF11, 3'b010, 2'd1);
        step();
        chk("lbu_a1", rf_wdata, 32'h0000_00FF);
        offer(2'b00, 1'b1, 5'd5, 32'h0080_FF11, 3'b101, 2'd2);
        step();
        chk("lw", rf_wdata, 32'h0080_FF11);

        // MULT then MFHI / MFLO back-to-back
        offer(2'b00, 1'b0, 5'd0, 32'h0, 3'b000, 2'b00);
        ms_hi_we = 1'b1; ms_lo_we = 1'b1; ms_hi_wdata = 32'h1; ms_lo_wdata = 32'h2;
        step();
        chk("mult_no_rf", rf_we, 0);
        offer(2'b01, 1'b1, 5'd4, 32'h0, 3'b000, 2'b00);
        ms_hi_read = 1'b1;
        step();
        chk("mfhi", rf_wdata, 32'h1);
        offer(2'b01, 1'b1, 5'd4, 32'h0, 3'b000, 2'b00);
        ms_lo_read = 1'b1;
        step();
        chk("mflo", rf_wdata, 32'h2);
        offer(2'b01, 1'b1, 5'd4, 32'h0, 3'b000, 2'b00);
        ms_hi_read = 1'b1; ms_lo_read = 1'b1;
        step();
        chk("hi_prio", rf_wdata, 32'h1);
        // Same-instruction write and read sees the old HI
        offer(2'b01, 1'b1, 5'd6, 32'h0, 3'b000, 2'b00);
        ms_hi_we = 1'b1; ms_hi_wdata = 32'h55; ms_hi_read = 1'b1;
        step();
        chk("hi_rd_old", rf_wdata, 32'h1);
        offer(2'b01, 1'b1, 5'd4, 32'h0, 3'b000, 2'b00);
        ms_hi_read = 1'b1;
        step();
        chk("hi_rd_new", rf_wdata, 32'h55);

        // Link, CP0, dest 0
        offer(2'b10, 1'b1, 5'd31, 32'h0, 3'b000, 2'b00);
        ms_pc = 32'hBFC0_0100;
        step();
        chk("jal", {rf_we, rf_waddr, rf_wdata}, {1'b1, 5'd31, 32'hBFC0_0108});
        offer(2'b10, 1'b1, 5'd31, 32'h0, 3'b000, 2'b00);
        ms_pc = 32'hFFFF_FFFC;
        step();
        chk("link_wrap", rf_wdata, 32'h0000_0004);
        offer(2'b11, 1'b1, 5'd7, 32'h0, 3'b000, 2'b00);
        ms_cp0_rdata = 32'hDEAD_BEEF;
        step();
        chk("cp0", rf_wdata, 32'hDEAD_BEEF);
        offer(2'b00, 1'b1, 5'd0, 32'hCAFE_0000, 3'b000, 2'b00);
        step();
        chk("dest0_we", rf_we, 0);
        chk("dest0_fwd", fwd_valid, 0);
        chk("dest0_dbg_wen", debug_wb_rf_wen, 0);

        // Stall for 3 cycles with a younger instruction waiting
        offer(2'b00, 1'b1, 5'd8, 32'h0000_A5A5, 3'b000, 2'b00);
        step();
        ws_stall = 1'b1;
        offer(2'b00, 1'b1, 5'd9, 32'h0000_0009, 3'b000, 2'b00);
        #1;
        chk("stall_we", rf_we, 0);
        chk("stall_fwd", {fwd_valid, fwd_dest, fwd_data}, {1'b1, 5'd8, 32'h0000_A5A5});
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_allowin", ws_allowin, 0);
        end
        ws_stall = 1'b0;
        #1;
        chk("release_we", {rf_we, rf_waddr}, {1'b1, 5'd8});
        step();
        ms_valid = 1'b0;
        chk("after_release", rf_waddr, 9);
        step();
        chk("stall_one_commit", commit_cnt[8], 1);
        chk("next_commit", commit_cnt[9], 1);

        // Flush of the offered instruction with WB empty
        offer(2'b00, 1'b1, 5'd10, 32'h10, 3'b000, 2'b00);
        ws_flush = 1'b1;
        step();
        ws_flush = 1'b0;
        ms_valid = 1'b0;
        chk("flush_fwd", fwd_valid, 0);
        step();
        chk("flush_no_commit", commit_cnt[10], 0);

        // Flush of the offered instruction while WB holds one: held still commits
        offer(2'b00, 1'b1, 5'd11, 32'h11, 3'b000, 2'b00);
        step();
        offer(2'b00, 1'b1, 5'd12, 32'h12, 3'b000, 2'b00);
        ws_flush = 1'b1;
        step();
        ws_flush = 1'b0;
        ms_valid = 1'b0;
        chk("flush_held_empty", fwd_valid, 0);
        chk("flush_held_commit", commit_cnt[11], 1);
        chk("flush_new_dropped", commit_cnt[12], 0);

        // Reset during stall drops held instruction and clears HI/LO
        offer(2'b00, 1'b0, 5'd0, 32'h0, 3'b000, 2'b00);
        ms_hi_we = 1'b1; ms_lo_we = 1'b1; ms_hi_wdata = 32'h77; ms_lo_wdata = 32'h88;
        step();
        offer(2'b01, 1'b1, 5'd13, 32'h0, 3'b000, 2'b00);
        ms_hi_read = 1'b1;
        step();
        ws_stall = 1'b1;
        ms_valid = 1'b0;
        #1;
        chk("pre_rst_fwd", fwd_data, 32'h77);
        step();
        reset = 1'b1;
        step();
        reset    = 1'b0;
        ws_stall = 1'b0;
        #1;
        chk("rst_stall_we", rf_we, 0);
        chk("rst_stall_fwd", fwd_valid, 0);
        step();
        chk("rst_stall_no_commit", commit_cnt[13], 0);
        offer(2'b01, 1'b1, 5'd14, 32'h0, 3'b000, 2'b00);
        ms_hi_read = 1'b1;
        step();
        chk("rst_hi_zero", {rf_we, rf_wdata}, {1'b1, 32'h0});
        offer(2'b01, 1'b1, 5'd15, 32'h0, 3'b000, 2'b00);
        ms_lo_read = 1'b1;
        step();
        chk("rst_lo_zero", {rf_we, rf_wdata}, {1'b1, 32'h0});
        ms_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
